// File: rtl/cache_way_data_select.sv
// N-way read-data selector for the set-associative data cache: registers the hitting way's word,
// pulses valid/miss, flags multi-way hits and keeps saturating hit/miss statistics.
//
// state  | meaning
// IDLE   | no lookup was sampled on the previous edge; both result pulses are low
// RESULT | a lookup was sampled on the previous edge; exactly one of DataValid_H / Miss_H is high
module cache_way_data_select #(
   parameter int WAYS   = 8,
   parameter int DATA_W = 16,
   parameter int CNT_W  = 16,
   parameter int WAY_W  = $clog2(WAYS)
) (
   input  logic                   Clock,
   input  logic                   Reset_H,
   input  logic                   Lookup_H,
   input  logic [WAYS-1:0]        ValidHit_H,
   input  logic [WAYS*DATA_W-1:0] Block_In,
   input  logic                   ClearStats_H,
   output logic [DATA_W-1:0]      DataOut,
   output logic                   DataValid_H,
   output logic                   Miss_H,
   output logic [WAY_W-1:0]       HitWay,
   output logic                   MultiHitErr_H,
   output logic [CNT_W-1:0]       HitCount,
   output logic [CNT_W-1:0]       MissCount
);

   typedef enum logic {IDLE, RESULT} state_t;

   state_t            state;
   logic              any_hit;
   logic              multi_hit;
   logic              single_hit;
   logic [WAY_W-1:0]  sel_way;
   logic [DATA_W-1:0] sel_data;

   // Clearing the lowest set bit leaves something only when two or more ways hit.
   assign any_hit    = |ValidHit_H;
   assign multi_hit  = |(ValidHit_H & (ValidHit_H - WAYS'(1)));
   assign single_hit = any_hit && !multi_hit;

   // OR-reduction mux; only consumed when exactly one way hits.
   always_comb begin
      sel_way  = '0;
      sel_data = '0;
      for (int i = 0; i < WAYS; i++) begin
         if (ValidHit_H[i]) begin
            sel_way  = sel_way | WAY_W'(i);
            sel_data = sel_data | Block_In[i*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset_H) begin
         state         <= IDLE;
         DataOut       <= '0;
         DataValid_H   <= 1'b0;
         Miss_H        <= 1'b0;
         HitWay        <= '0;
         MultiHitErr_H <= 1'b0;
         HitCount      <= '0;
         MissCount     <= '0;
      end else begin
         DataValid_H <= 1'b0;
         Miss_H      <= 1'b0;

         case (state)
            IDLE:    state <= Lookup_H ? RESULT : IDLE;
            RESULT:  state <= Lookup_H ? RESULT : IDLE;
            default: state <= IDLE;
         endcase

         if (Lookup_H) begin
            if (single_hit) begin
               DataOut     <= sel_data;
               HitWay      <= sel_way;
               DataValid_H <= 1'b1;
            end else begin
               Miss_H <= 1'b1;
            end
         end

         // A clear in the same cycle wins over the statistics update of a lookup.
         if (ClearStats_H) begin
            HitCount      <= '0;
            MissCount     <= '0;
            MultiHitErr_H <= 1'b0;
         end else if (Lookup_H) begin
            if (single_hit) begin
               if (HitCount != '1) HitCount <= HitCount + CNT_W'(1);
            end else begin
               if (MissCount != '1) MissCount <= MissCount + CNT_W'(1);
               if (multi_hit) MultiHitErr_H <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_cache_way_data_select.sv
// Scoreboard bench for cache_way_data_select: a behavioural model pushes the expected
// result of every driven cycle, which is popped and compared one edge later.
module tb_cache_way_data_select;

   localparam int WAYS   = 8;
   localparam int DATA_W = 16;
   localparam int CNT_W  = 4;
   localparam int WAY_W  = 3;

   logic                   Clock = 1'b0;
   logic                   Reset_H = 1'b1;
   logic                   Lookup_H = 1'b0;
   logic [WAYS-1:0]        ValidHit_H = '0;
   logic [WAYS*DATA_W-1:0] Block_In = '0;
   logic                   ClearStats_H = 1'b0;
   logic [DATA_W-1:0]      DataOut;
   logic                   DataValid_H;
   logic                   Miss_H;
   logic [WAY_W-1:0]       HitWay;
   logic                   MultiHitErr_H;
   logic [CNT_W-1:0]       HitCount;
   logic [CNT_W-1:0]       MissCount;

   cache_way_data_select #(
      .WAYS(WAYS), .DATA_W(DATA_W), .CNT_W(CNT_W), .WAY_W(WAY_W)
   ) dut (
      .Clock(Clock), .Reset_H(Reset_H), .Lookup_H(Lookup_H), .ValidHit_H(ValidHit_H),
      .Block_In(Block_In), .ClearStats_H(ClearStats_H), .DataOut(DataOut),
      .DataValid_H(DataValid_H), .Miss_H(Miss_H), .HitWay(HitWay),
      .MultiHitErr_H(MultiHitErr_H), .HitCount(HitCount), .MissCount(MissCount)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic              valid;
      logic              miss;
      logic [WAY_W-1:0]  way;
      logic              err;
      logic [CNT_W-1:0]  hc;
      logic [CNT_W-1:0]  mc;
   } exp_t;

   exp_t queue_exp[$];

   int errors = 0;
   int checks = 0;

   logic [DATA_W-1:0] m_data = '0;
   logic [WAY_W-1:0]  m_way = '0;
   logic              m_err = 1'b0;
   logic [CNT_W-1:0]  m_hc = '0;
   logic [CNT_W-1:0]  m_mc = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step(input logic rst, input logic lk, input logic clr,
                       input logic [WAYS-1:0] vh, input logic [WAYS*DATA_W-1:0] blk,
                       input string tag);
      exp_t e;
      exp_t o;
      int   n;
      @(negedge Clock);
      Reset_H      = rst;
      Lookup_H     = lk;
      ClearStats_H = clr;
      ValidHit_H   = vh;
      Block_In     = blk;
      e.valid = 1'b0;
      e.miss  = 1'b0;
      if (rst) begin
         m_data = '0; m_way = '0; m_err = 1'b0; m_hc = '0; m_mc = '0;
      end else begin
         if (lk) begin
            n = $countones(vh);
            if (n == 1) begin
               for (int i = 0; i < WAYS; i++)
                  if (vh[i]) begin
                     m_data = blk[i*DATA_W +: DATA_W];
                     m_way  = WAY_W'(i);
                  end
               e.valid = 1'b1;
               if (!clr && m_hc != 4'd15) m_hc = m_hc + 4'd1;
            end else begin
               e.miss = 1'b1;
               if (!clr && m_mc != 4'd15) m_mc = m_mc + 4'd1;
               if (!clr && n > 1) m_err = 1'b1;
            end
         end
         if (clr) begin
            m_hc = '0; m_mc = '0; m_err = 1'b0;
         end
      end
      e.data = m_data; e.way = m_way; e.err = m_err; e.hc = m_hc; e.mc = m_mc;
      queue_exp.push_back(e);

      @(posedge Clock);
      #1;
      o = queue_exp.pop_front();
      check({tag, ".data"},  32'(DataOut),       32'(o.data));
      check({tag, ".valid"}, 32'(DataValid_H),   32'(o.valid));
      check({tag, ".miss"},  32'(Miss_H),        32'(o.miss));
      check({tag, ".way"},   32'(HitWay),        32'(o.way));
      check({tag, ".err"},   32'(MultiHitErr_H), 32'(o.err));
      check({tag, ".hcnt"},  32'(HitCount),      32'(o.hc));
      check({tag, ".mcnt"},  32'(MissCount),     32'(o.mc));
   endtask

   function automatic logic [WAYS*DATA_W-1:0] rand_block();
      logic [WAYS*DATA_W-1:0] b;
      for (int i = 0; i < WAYS; i++) b[i*DATA_W +: DATA_W] = DATA_W'($urandom);
      return b;
   endfunction

   function automatic logic [WAYS*DATA_W-1:0] put_word(input logic [WAYS*DATA_W-1:0] b,
                                                       input int way, input logic [DATA_W-1:0] w);
      logic [WAYS*DATA_W-1:0] r;
      r = b;
      r[way*DATA_W +: DATA_W] = w;
      return r;
   endfunction

   initial begin
      logic [WAYS-1:0] vh;
      int mode;

      step(1'b1, 1'b0, 1'b0, '0, '0, "reset");
      step(1'b1, 1'b0, 1'b0, '0, '0, "reset2");

      step(1'b0, 1'b1, 1'b0, 8'b0000_0100, put_word(rand_block(), 2, 16'hBEEF), "hit2");
      step(1'b0, 1'b0, 1'b0, 8'b0000_0100, rand_block(), "idle_after_hit");
      step(1'b0, 1'b1, 1'b0, 8'b0000_0000, rand_block(), "miss");

      step(1'b0, 1'b1, 1'b0, 8'b1000_0001, rand_block(), "multi");
      for (int k = 0; k < 3; k++)
         step(1'b0, 1'b1, 1'b0, 8'(1) << k, rand_block(), "hit_after_multi");
      step(1'b0, 1'b0, 1'b1, 8'hFF, rand_block(), "clear");

      for (int k = 0; k < 20; k++)
         step(1'b0, 1'b1, 1'b0, 8'(1) << (k % 8), rand_block(), "sat_hit");
      for (int k = 0; k < 18; k++)
         step(1'b0, 1'b1, 1'b0, (k % 2) ? 8'h00 : 8'h11, rand_block(), "sat_miss");

      step(1'b0, 1'b1, 1'b1, 8'b1000_0000, put_word(rand_block(), 7, 16'h1234), "clear_hit7");
      step(1'b0, 1'b1, 1'b1, 8'b0110_0000, rand_block(), "clear_multi");

      for (int k = 0; k < 40; k++) begin
         mode = int'($urandom_range(0, 3));
         case (mode)
            0:       vh = '0;
            1, 2:    vh = 8'(1) << $urandom_range(0, 7);
            default: vh = 8'($urandom);
         endcase
         step(1'b0, ($urandom_range(0, 4) != 0), ($urandom_range(0, 9) == 0), vh,
              rand_block(), "random");
      end

      step(1'b0, 1'b1, 1'b0, 8'b0000_1000, rand_block(), "pre_reset_hit");
      step(1'b1, 1'b1, 1'b0, 8'b0000_0010, rand_block(), "reset_with_hit");
      step(1'b0, 1'b0, 1'b0, '0, rand_block(), "after_reset");
      step(1'b0, 1'b1, 1'b0, 8'b0010_0000, rand_block(), "hit_after_reset");

      check("queue_empty", 32'(queue_exp.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
